// File: rtl/huff_pkg.sv
// huff_pkg: phase encoding and SRAM owner codes shared by the phase sequencer and the SRAM mux.
package huff_pkg;
  typedef enum logic [3:0] {IDLE, LOAD, FREQ, HUFF_GO, HUFF, ENC_GO, ENC, DONE, ERROR} phase_t;
  localparam logic [2:0] SEL_IDLE = 3'b000;
  localparam logic [2:0] SEL_BUS  = 3'b001;
  localparam logic [2:0] SEL_SYM  = 3'b010;
  localparam logic [2:0] SEL_NODE = 3'b011;
  localparam logic [2:0] SEL_MC   = 3'b100;
  function automatic logic [2:0] sel_of(phase_t p);
    return p == LOAD ? SEL_BUS :
           p == FREQ ? SEL_SYM :
           (p == HUFF_GO || p == HUFF) ? SEL_NODE :
           (p == ENC_GO || p == ENC) ? SEL_MC : SEL_IDLE;
  endfunction
  // Phases that wait on an engine and are therefore guarded by the watchdog.
  function automatic logic timed(phase_t p);
    return p == LOAD || p == FREQ || p == HUFF || p == ENC;
  endfunction
endpackage

// File: rtl/huff_phase_ctrl_if.sv
// huff_phase_ctrl_if: host/engine handshakes and SRAM owner select of the phase sequencer.
interface huff_phase_ctrl_if;
  logic start_det;
  logic EOT_flag;
  logic freq_done;
  logic huff_done;
  logic enc_done;
  logic abort;
  logic [2:0] sram_sel;
  logic load_enable;
  logic freq_enable;
  logic huff_start;
  logic enc_start;
  logic busy;
  logic done;
  logic error;
  modport master (
    input  start_det, EOT_flag, freq_done, huff_done, enc_done, abort,
    output sram_sel, load_enable, freq_enable, huff_start, enc_start, busy, done, error
  );
  modport slave (
    output start_det, EOT_flag, freq_done, huff_done, enc_done, abort,
    input  sram_sel, load_enable, freq_enable, huff_start, enc_start, busy, done, error
  );
endinterface

// File: rtl/phase_timer.sv
// phase_timer: saturating per-phase watchdog counter flagging the last allowed cycle.
module phase_timer #(
  parameter int TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT - 1'b1;
  logic [TIMEOUT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!n_rst || clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  assign hit = cnt == LAST;
endmodule

// File: rtl/huff_phase_ctrl.sv
// huff_phase_ctrl: steps the Huffman core through load/freq/tree/encode and owns the SRAM select.
module huff_phase_ctrl
  import huff_pkg::*;
#(
  parameter int TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic clk,
  input  logic n_rst,
  huff_phase_ctrl_if.master bus
);
  phase_t state, nxt;
  logic hit;
  always_ff @(posedge clk) state <= n_rst ? nxt : IDLE;
  // Exit conditions are tested before hit so a same-cycle done beats the watchdog.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start_det ? LOAD : IDLE;
      LOAD:    nxt = bus.EOT_flag ? FREQ : hit ? ERROR : LOAD;
      FREQ:    nxt = bus.freq_done ? HUFF_GO : hit ? ERROR : FREQ;
      HUFF_GO: nxt = HUFF;
      HUFF:    nxt = bus.huff_done ? ENC_GO : hit ? ERROR : HUFF;
      ENC_GO:  nxt = ENC;
      ENC:     nxt = bus.enc_done ? DONE : hit ? ERROR : ENC;
      DONE:    nxt = IDLE;
      default: nxt = ERROR;
    endcase
    if (bus.abort) nxt = IDLE;
  end
  phase_timer #(.TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .n_rst(n_rst),
    .clr(nxt != state),
    .en(timed(state)),
    .hit(hit)
  );
  assign bus.sram_sel    = sel_of(state);
  assign bus.load_enable = state == LOAD;
  assign bus.freq_enable = state == FREQ;
  assign bus.huff_start  = state == HUFF_GO;
  assign bus.enc_start   = state == ENC_GO;
  assign bus.busy        = state != IDLE && state != ERROR;
  assign bus.done        = state == DONE;
  assign bus.error       = state == ERROR;
endmodule

// File: doc/huff_phase_ctrl.md
# huff_phase_ctrl

Top-level phase sequencer for the Huffman compression core. It steps the core through its phases: input load, frequency count, tree build and encode. It hands out the shared SRAM port by driving the 3-bit select code consumed by the SRAM mux, and it runs start/done handshakes with each phase engine. A per-phase watchdog forces a sticky error state if an engine stalls.

## Interface
Parameters:
- TIMEOUT_W, 16, width of the watchdog counter.
- TIMEOUT, 16'hFFFF, maximum number of cycles any single phase may last before an error is raised.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset, synchronous and active-low.
- start_det  in  1  host detected start of a transfer; sampled only in IDLE.
- EOT_flag  in  1  end of text from the bus loader; ends LOAD.
- freq_done  in  1  frequency counter finished.
- huff_done  in  1  tree builder finished.
- enc_done  in  1  encoder finished.
- abort  in  1  cancel the current job; also clears ERROR.
- sram_sel  out  3  SRAM owner code: 000 idle, 001 bus, 010 sym, 011 node, 100 mc.
- load_enable  out  1  level; high throughout LOAD.
- freq_enable  out  1  level; high throughout FREQ.
- huff_start  out  1  one-cycle pulse that starts the tree builder.
- enc_start  out  1  one-cycle pulse that starts the encoder.
- busy  out  1  high in any state other than IDLE and ERROR.
- done  out  1  one-cycle pulse when a job completes.
- error  out  1  high while in ERROR.

## Operation
States and their sram_sel values:
- IDLE: 000.
- LOAD: 001.
- FREQ: 010.
- HUFF_GO: 011.
- HUFF: 011.
- ENC_GO: 100.
- ENC: 100.
- DONE: 000.
- ERROR: 000.

Transitions:
- IDLE to LOAD on start_det.
- LOAD to FREQ on EOT_flag.
- FREQ to HUFF_GO on freq_done.
- HUFF_GO to HUFF unconditionally.
- HUFF to ENC_GO on huff_done.
- ENC_GO to ENC unconditionally.
- ENC to DONE on enc_done.
- DONE to IDLE unconditionally.

Outputs per state:
- All outputs are Moore, decoded from the registered state only.
- huff_start is high only in HUFF_GO.
- enc_start is high only in ENC_GO.
- done is high only in DONE.
- load_enable and freq_enable are high only in LOAD and FREQ respectively.

Watchdog:
- The counter clears on every state change.
- It increments each cycle in LOAD, FREQ, HUFF and ENC.
- When the count equals TIMEOUT-1 and the phase's exit condition is false, the next state is ERROR.
- The counter saturates; it never wraps.

Priority and boundary rules:
- abort has the highest priority. From any state other than IDLE, the next state is IDLE.
- ERROR is left only via abort, to IDLE. start_det is ignored in ERROR.
- A phase exit condition beats the watchdog when both are true in the same cycle.
- start_det outside IDLE is ignored.
- A done input or EOT_flag arriving outside its own phase is ignored. It is not remembered.
- A done input already high on the cycle the machine enters its phase is accepted on that cycle.
- A reset in mid-job takes priority over everything. The machine returns to IDLE at the next edge and no done pulse is emitted.

## Timing
- Reset values: state IDLE, sram_sel 000, every other output 0, watchdog 0.
- One-cycle response rule: an input sampled at edge k changes the outputs after edge k.
  - Example: start_det at edge k gives sram_sel=001 and load_enable=1 during cycle k+1.
- sram_sel changes on the same edge as the enables. An engine never sees its enable without also owning the SRAM.
- Minimum job length is 7 cycles from start_det to the done pulse, with every done input asserted immediately:
  - LOAD, FREQ, HUFF_GO, HUFF, ENC_GO, ENC and DONE, one cycle each.
- huff_start and enc_start are exactly one cycle wide. The engine must register them.

## Structure
- Package huff_pkg holds:
  - the state enum phase_t;
  - the select constants SEL_IDLE, SEL_BUS, SEL_SYM, SEL_NODE and SEL_MC.
- The SRAM mux imports the same select constants.
- One sub-module, phase_timer: a saturating counter with clear and enable inputs and a hit output at TIMEOUT-1, parameterized by TIMEOUT_W and TIMEOUT.
- The FSM is a single registered state plus a combinational next-state block and output decode.

## Test plan
- Nominal job: reset, then start_det, EOT_flag 3 cycles later, freq_done 5 cycles later, huff_done 4 cycles later, enc_done 2 cycles later.
  - Required: sram_sel sequence 000→001→010→011→100→000.
  - Required: one huff_start pulse, one enc_start pulse, one done pulse.
  - Required: busy is low again the cycle after done.
- Back-to-back dones: all done inputs held high from the start.
  - Required: exactly 7 cycles from start_det to done.
- Watchdog: TIMEOUT=8, freq_done never asserted.
  - Required: ERROR entered 8 cycles after FREQ entry, with error=1 and sram_sel=000.
  - Required: start_det is ignored in ERROR; abort returns the machine to IDLE.
- Watchdog tie: with TIMEOUT=8, assert huff_done on the 8th HUFF cycle.
  - Required: the next state is ENC_GO, not ERROR.
- Abort mid-ENC: assert abort, with enc_done also asserted in the same cycle.
  - Required: IDLE next cycle, no done pulse, sram_sel=000.
- Reset mid-FREQ: drive n_rst=0 for 1 cycle.
  - Required: all outputs at reset values after the edge.
  - Required: a freq_done that arrives later is ignored.
